// File: rtl/zero_indices_pkg.sv
// Shared types and width constants for the zero-index stream (producer and gather side).
package zero_indices_pkg;

  localparam int W_DEFAULT = 32;
  localparam int IDX_W     = $clog2(W_DEFAULT);
  localparam int CNT_W     = $clog2(W_DEFAULT + 1);

  typedef logic [W_DEFAULT-1:0] w_t;
  typedef logic [IDX_W-1:0]     idx_t;
  typedef logic [CNT_W-1:0]     cnt_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

endpackage

// File: rtl/zero_indices_onehot.sv
// Combinational index -> one-hot decoder with an in-range flag.
// The flag is low for indices >= W when W is not a power of two.
module zero_indices_onehot #(
  parameter int W  = 32,
  parameter int IW = $clog2(W)
) (
  input  logic [IW-1:0] i_idx,
  output logic [W-1:0]  o_onehot,
  output logic          o_in_range
);

  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_dec
      assign o_onehot[gi] = (i_idx == IW'(gi));
    end
  endgenerate

  assign o_in_range = (32'(i_idx) < 32'(W));

endmodule

// File: rtl/zero_indices_gather.sv
// Rebuilds a W-bit vector (all ones, zeros at received indices) from an index stream.
// Optional macro ZERO_INDICES_GATHER_ORDER_CHK_EN flags non-ascending indices within a frame.
module zero_indices_gather
  import zero_indices_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [$clog2(W)-1:0]   in_index,
  input  logic                   in_none,
  input  logic                   in_last,
  output logic                   in_ready,
  output logic                   out_valid_r,
  output logic [W-1:0]           out_vector_r,
  output logic [$clog2(W+1)-1:0] out_count_r,
  output logic                   out_err_r,
  input  logic                   out_ready
);

  localparam int IW = $clog2(W);
  localparam int CW = $clog2(W + 1);

  state_t          r_state;
  logic            w_accept;
  logic            w_first;
  logic [W-1:0]    w_onehot;
  logic            w_in_range;
  logic [W-1:0]    w_base_vec;
  logic [CW-1:0]   w_base_cnt;
  logic            w_base_err;
  logic [W-1:0]    w_vec_next;
  logic [CW-1:0]   w_cnt_next;
  logic            w_err_next;

`ifdef ZERO_INDICES_GATHER_ORDER_CHK_EN
  logic [IW-1:0]   r_prev;
  logic            r_prev_vld;
`endif

  zero_indices_onehot #(.W(W), .IW(IW)) u_onehot (
    .i_idx      (in_index),
    .o_onehot   (w_onehot),
    .o_in_range (w_in_range)
  );

  assign in_ready = (r_state != HOLD);
  assign w_accept = in_valid && in_ready;
  assign w_first  = (r_state == IDLE);

  // A frame starts from a clean slate; later beats build on the held working state.
  assign w_base_vec = w_first ? '1 : out_vector_r;
  assign w_base_cnt = w_first ? '0 : out_count_r;
  assign w_base_err = w_first ? 1'b0 : out_err_r;

  always_comb begin
    w_vec_next = w_base_vec;
    w_cnt_next = w_base_cnt;
    w_err_next = w_base_err;
    if (in_none) begin
      // "No zeros" is only legal as the sole beat of a frame.
      if (!in_last || !w_first) w_err_next = 1'b1;
    end else if (!w_in_range) begin
      w_err_next = 1'b1;
    end else if ((w_base_vec & w_onehot) == '0) begin
      w_err_next = 1'b1;
    end else begin
      w_vec_next = w_base_vec & ~w_onehot;
      w_cnt_next = (w_base_cnt == CW'(W)) ? CW'(W) : w_base_cnt + CW'(1);
    end
`ifdef ZERO_INDICES_GATHER_ORDER_CHK_EN
    if (!in_none && !w_first && r_prev_vld && (in_index <= r_prev)) w_err_next = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      out_valid_r  <= 1'b0;
      out_err_r    <= 1'b0;
      out_count_r  <= '0;
      out_vector_r <= '1;
    end else begin
      case (r_state)
        IDLE, COLLECT: begin
          if (w_accept) begin
            out_vector_r <= w_vec_next;
            out_count_r  <= w_cnt_next;
            out_err_r    <= w_err_next;
            out_valid_r  <= in_last;
            r_state      <= in_last ? HOLD : COLLECT;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef ZERO_INDICES_GATHER_ORDER_CHK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev     <= '0;
      r_prev_vld <= 1'b0;
    end else if (w_accept) begin
      if (w_first) r_prev_vld <= !in_none;
      else if (!in_none) r_prev_vld <= 1'b1;
      if (!in_none) r_prev <= in_index;
    end
  end
`endif

endmodule

// File: tb/tb_zero_indices_gather.sv
// Self-checking bench for zero_indices_gather at W=8: directed spec cases plus random frames vs a set-based model.
module tb_zero_indices_gather;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [2:0] in_index;
  logic       in_none;
  logic       in_last;
  logic       in_ready;
  logic       out_valid_r;
  logic [7:0] out_vector_r;
  logic [3:0] out_count_r;
  logic       out_err_r;
  logic       out_ready;

  int n_cmp = 0;
  int n_bad = 0;

  int b_idx [16];
  bit b_none[16];
  int nb;

  always #5 clk = ~clk;

  zero_indices_gather #(.W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_index     (in_index),
    .in_none      (in_none),
    .in_last      (in_last),
    .in_ready     (in_ready),
    .out_valid_r  (out_valid_r),
    .out_vector_r (out_vector_r),
    .out_count_r  (out_count_r),
    .out_err_r    (out_err_r),
    .out_ready    (out_ready)
  );

  // Reference: the set of distinct received indices; everything else is a rule violation.
  function automatic void model(output logic [7:0] v, output int c, output bit e);
    bit seen[8];
    int prev;
    v = 8'hFF; c = 0; e = 0; prev = -1;
    for (int k = 0; k < 8; k++) seen[k] = 0;
    for (int i = 0; i < nb; i++) begin
      if (b_none[i]) begin
        if (!(i == 0 && nb == 1)) e = 1;
      end else begin
        if (b_idx[i] >= 8) e = 1;
        else if (seen[b_idx[i]]) e = 1;
        else begin
          seen[b_idx[i]] = 1;
          c = c + 1;
        end
`ifdef ZERO_INDICES_GATHER_ORDER_CHK_EN
        if (prev >= 0 && b_idx[i] <= prev) e = 1;
`endif
        prev = b_idx[i];
      end
    end
    for (int k = 0; k < 8; k++) if (seen[k]) v = v & ~(8'h01 << k);
  endfunction

  task automatic send_beat(input int idx, input bit none, input bit last);
    int t = 0;
    in_valid = 1'b1; in_index = 3'(idx); in_none = none; in_last = last;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1; t++;
    end
    n_cmp++;
    if (!in_ready) begin
      n_bad++;
      $display("FAIL send_timeout: in_ready=%0b required 1 within 50 cycles", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_none = 1'b0; in_last = 1'b0;
  endtask

  task automatic handshake(input string name);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid_r !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_release: out_valid_r=%0b required 0", name, out_valid_r);
    end
  endtask

  // Sends the loaded beats, checks latency and result; literal expectations override the model.
  task automatic run_frame(input string name, input bit gaps, input bit use_lit,
                           input logic [7:0] lv, input int lc, input bit le);
    logic [7:0] ev; int ec; bit ee;
    model(ev, ec, ee);
    if (use_lit) begin ev = lv; ec = lc; ee = le; end
    for (int i = 0; i < nb; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(posedge clk);
      if (gaps) #1;
      send_beat(b_idx[i], b_none[i], i == nb - 1);
    end
    n_cmp++;
    if (out_valid_r !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_latency: out_valid_r=%0b required 1", name, out_valid_r);
    end
    if (gaps) repeat ($urandom_range(0, 2)) @(posedge clk);
    if (gaps) #1;
    n_cmp++;
    if (out_vector_r !== ev || out_count_r !== 4'(ec) || out_err_r !== ee) begin
      n_bad++;
      $display("FAIL %s_result: vec=%h cnt=%0d err=%0b required vec=%h cnt=%0d err=%0b",
               name, out_vector_r, out_count_r, out_err_r, ev, ec, ee);
    end
    $display("frame %s beats=%0d vec=%h cnt=%0d err=%0b", name, nb, out_vector_r, out_count_r, out_err_r);
    handshake(name);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 0; in_index = 0; in_none = 0; in_last = 0; out_ready = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n_cmp++;
    if (out_valid_r !== 1'b0 || out_err_r !== 1'b0 || out_count_r !== 4'd0 ||
        out_vector_r !== 8'hFF || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset: valid=%0b err=%0b cnt=%0d vec=%h rdy=%0b required 0 0 0 ff 1",
               out_valid_r, out_err_r, out_count_r, out_vector_r, in_ready);
    end
    $display("reset vec=%h cnt=%0d", out_vector_r, out_count_r);
  endtask

  task automatic test_directed();
    nb = 3; b_idx[0] = 1; b_idx[1] = 4; b_idx[2] = 6;
    for (int i = 0; i < 3; i++) b_none[i] = 0;
    run_frame("idx_1_4_6", 0, 1, 8'hAD, 3, 0);
    nb = 1; b_idx[0] = 0; b_none[0] = 1;
    run_frame("none_only", 0, 1, 8'hFF, 0, 0);
    nb = 2; b_idx[0] = 2; b_idx[1] = 2; b_none[0] = 0; b_none[1] = 0;
    run_frame("dup_2_2", 0, 1, 8'hFB, 1, 1);
    nb = 2; b_idx[0] = 4; b_idx[1] = 0; b_none[0] = 0; b_none[1] = 1;
    run_frame("none_in_collect", 0, 1, 8'hEF, 1, 1);
  endtask

  task automatic test_order();
    nb = 2; b_idx[0] = 5; b_idx[1] = 3; b_none[0] = 0; b_none[1] = 0;
`ifdef ZERO_INDICES_GATHER_ORDER_CHK_EN
    run_frame("order_5_3", 0, 1, 8'hD7, 2, 1);
`else
    run_frame("order_5_3", 0, 1, 8'hD7, 2, 0);
`endif
  endtask

  task automatic test_backpressure();
    nb = 2; b_idx[0] = 3; b_idx[1] = 6; b_none[0] = 0; b_none[1] = 0;
    for (int i = 0; i < nb; i++) send_beat(b_idx[i], 0, i == nb - 1);
    in_valid = 1'b1; in_index = 3'd0; in_none = 1'b0; in_last = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (in_ready !== 1'b0 || out_valid_r !== 1'b1 || out_vector_r !== 8'hB7 ||
          out_count_r !== 4'd2 || out_err_r !== 1'b0) begin
        n_bad++;
        $display("FAIL hold_stable: rdy=%0b valid=%0b vec=%h cnt=%0d err=%0b required 0 1 b7 2 0",
                 in_ready, out_valid_r, out_vector_r, out_count_r, out_err_r);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid_r !== 1'b0) begin
      n_bad++;
      $display("FAIL hold_release: rdy=%0b valid=%0b required 1 0", in_ready, out_valid_r);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    n_cmp++;
    if (out_valid_r !== 1'b1 || out_vector_r !== 8'hFE || out_count_r !== 4'd1) begin
      n_bad++;
      $display("FAIL frame2: valid=%0b vec=%h cnt=%0d required 1 fe 1", out_valid_r, out_vector_r, out_count_r);
    end
    $display("frame backpressure_f2 vec=%h cnt=%0d err=%0b", out_vector_r, out_count_r, out_err_r);
    handshake("frame2");
  endtask

  task automatic test_mid_reset();
    send_beat(0, 0, 0);
    send_beat(3, 0, 0);
    send_beat(5, 0, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++;
    if (out_valid_r !== 1'b0 || out_err_r !== 1'b0 || out_count_r !== 4'd0 ||
        out_vector_r !== 8'hFF || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_reset: valid=%0b err=%0b cnt=%0d vec=%h rdy=%0b required 0 0 0 ff 1",
               out_valid_r, out_err_r, out_count_r, out_vector_r, in_ready);
    end
    nb = 1; b_idx[0] = 7; b_none[0] = 0;
    run_frame("after_reset_7", 0, 1, 8'h7F, 1, 0);
  endtask

  task automatic test_random();
    for (int f = 0; f < 25; f++) begin
      nb = $urandom_range(1, 6);
      for (int i = 0; i < nb; i++) begin
        b_idx[i]  = $urandom_range(0, 7);
        b_none[i] = ($urandom_range(0, 9) == 0);
      end
      run_frame($sformatf("rand%0d", f), 1, 0, 8'h00, 0, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_order();
    test_backpressure();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
